// File: rtl/prog_load_if.sv
// Load/run bus between the serial host, the core memories and the load controller.
// Signal names keep the legacy port names of prog_load_ctrl.
interface prog_load_if #(
  parameter int IW  = 16,
  parameter int DW  = 8,
  parameter int IAW = 4,
  parameter int DAW = 4
);
  logic           proc_en_i;
  logic           csi_n_i;
  logic           csd_n_i;
  logic           mosi_i;
  logic           core_done_i;
  logic           imem_we_o;
  logic [IAW-1:0] imem_addr_o;
  logic [IW-1:0]  imem_wdata_o;
  logic           dmem_we_o;
  logic [DAW-1:0] dmem_addr_o;
  logic [DW-1:0]  dmem_wdata_o;
  logic           core_rst_o;
  logic           core_run_o;
  logic           busy_o;
  logic           done_o;
  logic           err_o;

  modport master (
    output proc_en_i, csi_n_i, csd_n_i, mosi_i, core_done_i,
    input  imem_we_o, imem_addr_o, imem_wdata_o,
    input  dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  core_rst_o, core_run_o, busy_o, done_o, err_o
  );

  modport slave (
    input  proc_en_i, csi_n_i, csd_n_i, mosi_i, core_done_i,
    output imem_we_o, imem_addr_o, imem_wdata_o,
    output dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output core_rst_o, core_run_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// Load/run sequencer: shifts serial program/data frames into memory words,
// then releases the core from reset on proc_en and latches its done flag.
module prog_load_ctrl #(
  parameter int IW  = 16,
  parameter int DW  = 8,
  parameter int IAW = 4,
  parameter int DAW = 4
) (
  input  logic      clk,
  input  logic      rst,
  prog_load_if.slave bus
);

  localparam int SW = (IW > DW) ? IW : DW;
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [SW-1:0]  sr;
  logic [CW-1:0]  cnt;
  logic [IAW-1:0] iaddr;
  logic [DAW-1:0] daddr;
  logic           imem_we, dmem_we;
  logic [IW-1:0]  imem_wdata;
  logic [DW-1:0]  dmem_wdata;
  logic           err;
  logic           err_set;
  logic           shift_i, shift_d, entry_i, entry_d, last_bit;

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    case (state)
      S_IDLE: begin
        // frame selects take priority over a pending run request
        if (!bus.csi_n_i && bus.csd_n_i)       state_nx = S_LOAD_I;
        else if (bus.csi_n_i && !bus.csd_n_i)  state_nx = S_LOAD_D;
        else if (!bus.csi_n_i && !bus.csd_n_i) err_set  = 1'b1;
        else if (bus.proc_en_i)                state_nx = S_RUN;
      end
      S_LOAD_I: if (bus.csi_n_i) state_nx = S_IDLE;
      S_LOAD_D: if (bus.csd_n_i) state_nx = S_IDLE;
      S_RUN: begin
        if (!bus.proc_en_i)       state_nx = S_IDLE;
        else if (bus.core_done_i) state_nx = S_DONE;
      end
      S_DONE:  if (!bus.proc_en_i) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shifting follows the next state so the entry cycle already samples bit 1.
  assign shift_i  = (state_nx == S_LOAD_I);
  assign shift_d  = (state_nx == S_LOAD_D);
  assign entry_i  = (state == S_IDLE) && shift_i;
  assign entry_d  = (state == S_IDLE) && shift_d;
  assign last_bit = shift_i ? (cnt == CW'(IW - 1)) : (cnt == CW'(DW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sr         <= '0;
      cnt        <= '0;
      iaddr      <= '0;
      daddr      <= '0;
      imem_we    <= 1'b0;
      dmem_we    <= 1'b0;
      imem_wdata <= '0;
      dmem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      state   <= state_nx;
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      if (err_set) err <= 1'b1;

      if (entry_i)      iaddr <= '0;
      else if (imem_we) iaddr <= iaddr + 1'b1;
      if (entry_d)      daddr <= '0;
      else if (dmem_we) daddr <= daddr + 1'b1;

      if (shift_i || shift_d) begin
        sr <= {sr[SW-2:0], bus.mosi_i};
        if (last_bit) begin
          cnt <= '0;
          if (shift_i) begin
            imem_we    <= 1'b1;
            imem_wdata <= {sr[IW-2:0], bus.mosi_i};
          end else begin
            dmem_we    <= 1'b1;
            dmem_wdata <= {sr[DW-2:0], bus.mosi_i};
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        sr  <= '0;
        cnt <= '0;
      end
    end
  end

  assign bus.imem_we_o    = imem_we;
  assign bus.imem_addr_o  = iaddr;
  assign bus.imem_wdata_o = imem_wdata;
  assign bus.dmem_we_o    = dmem_we;
  assign bus.dmem_addr_o  = daddr;
  assign bus.dmem_wdata_o = dmem_wdata;
  assign bus.core_rst_o   = (state == S_IDLE) || (state == S_LOAD_I) || (state == S_LOAD_D);
  assign bus.core_run_o   = (state == S_RUN);
  assign bus.busy_o       = (state == S_LOAD_I) || (state == S_LOAD_D);
  assign bus.done_o       = (state == S_DONE);
  assign bus.err_o        = err;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: queue-based reference model compared
// every cycle, directed load/run scenarios with literal expectations, then random traffic.
module tb_prog_load_ctrl;
  localparam int IW = 16, DW = 8, IAW = 4, DAW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_load_if #(.IW(IW), .DW(DW), .IAW(IAW), .DAW(DAW)) bus ();
  prog_load_ctrl #(.IW(IW), .DW(DW), .IAW(IAW), .DAW(DAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 loading instructions, 2 loading data, 3 running, 4 finished
  int             mode;
  bit             iq[$];
  bit             dq[$];
  logic [IAW-1:0] m_iaddr, m_iwa;
  logic [DAW-1:0] m_daddr, m_dwa;
  logic           m_iwe, m_dwe, m_err;
  logic [IW-1:0]  m_iword;
  logic [DW-1:0]  m_dword;

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] w = 0;
    foreach (q[k]) w = (w << 1) | 32'(q[k]);
    return w;
  endfunction

  task automatic take_i();
    iq.push_back(bus.mosi_i);
    if (iq.size() == IW) begin
      m_iwe = 1; m_iword = IW'(pack(iq)); m_iwa = m_iaddr; iq.delete();
    end
  endtask

  task automatic take_d();
    dq.push_back(bus.mosi_i);
    if (dq.size() == DW) begin
      m_dwe = 1; m_dword = DW'(pack(dq)); m_dwa = m_daddr; dq.delete();
    end
  endtask

  task automatic model_step();
    if (rst) begin
      mode = 0; iq.delete(); dq.delete();
      m_iaddr = 0; m_daddr = 0; m_iwe = 0; m_dwe = 0; m_err = 0;
      m_iwa = 0; m_dwa = 0; m_iword = 0; m_dword = 0;
      return;
    end
    if (m_iwe) m_iaddr = m_iaddr + 1'b1;
    if (m_dwe) m_daddr = m_daddr + 1'b1;
    m_iwe = 0; m_dwe = 0;
    case (mode)
      0: begin
        if (!bus.csi_n_i && bus.csd_n_i) begin
          mode = 1; m_iaddr = 0; iq.delete(); take_i();
        end else if (bus.csi_n_i && !bus.csd_n_i) begin
          mode = 2; m_daddr = 0; dq.delete(); take_d();
        end else if (!bus.csi_n_i && !bus.csd_n_i) m_err = 1;
        else if (bus.proc_en_i) mode = 3;
      end
      1: if (bus.csi_n_i) begin mode = 0; iq.delete(); end else take_i();
      2: if (bus.csd_n_i) begin mode = 0; dq.delete(); end else take_d();
      3: if (!bus.proc_en_i) mode = 0; else if (bus.core_done_i) mode = 4;
      4: if (!bus.proc_en_i) mode = 0;
      default: mode = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- compare process ----------------
  logic [IW-1:0]  obs_i[16];
  logic [DW-1:0]  obs_d[16];
  int             n_iw = 0, n_dw = 0;
  logic [IAW-1:0] last_ia = 0;
  logic [DAW-1:0] last_da = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("core_rst", bus.core_rst_o, 32'(mode <= 2));
      chk("core_run", bus.core_run_o, 32'(mode == 3));
      chk("busy", bus.busy_o, 32'(mode == 1 || mode == 2));
      chk("done", bus.done_o, 32'(mode == 4));
      chk("err", bus.err_o, m_err);
      chk("imem_we", bus.imem_we_o, m_iwe);
      chk("dmem_we", bus.dmem_we_o, m_dwe);
      if (m_iwe) begin
        chk("imem_addr", bus.imem_addr_o, m_iwa);
        chk("imem_wdata", bus.imem_wdata_o, m_iword);
      end
      if (m_dwe) begin
        chk("dmem_addr", bus.dmem_addr_o, m_dwa);
        chk("dmem_wdata", bus.dmem_wdata_o, m_dword);
      end
      if (bus.imem_we_o) begin
        obs_i[bus.imem_addr_o] = bus.imem_wdata_o; last_ia = bus.imem_addr_o; n_iw++;
      end
      if (bus.dmem_we_o) begin
        obs_d[bus.dmem_addr_o] = bus.dmem_wdata_o; last_da = bus.dmem_addr_o; n_dw++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.mosi_i = w[n-1-i];
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst"}, bus.core_rst_o, 1);
    chk({tag, "_core_run"}, bus.core_run_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
    chk({tag, "_err"}, bus.err_o, 0);
    chk({tag, "_imem_we"}, bus.imem_we_o, 0);
    chk({tag, "_dmem_we"}, bus.dmem_we_o, 0);
    chk({tag, "_imem_addr"}, bus.imem_addr_o, 0);
  endtask

  initial begin
    int base_i, base_d;
    bus.csi_n_i = 1; bus.csd_n_i = 1; bus.mosi_i = 0;
    bus.proc_en_i = 0; bus.core_done_i = 0;
    #1 chk_reset_vals("rst");
    tick(); tick();
    rst = 0;
    tick();

    // two back-to-back instruction words
    base_i = n_iw;
    bus.csi_n_i = 0;
    send({32'h0, 16'hA5F0, 16'h1234}, 32);
    bus.csi_n_i = 1;
    tick(); tick();
    chk("iload_count", n_iw - base_i, 2);
    chk("iload_w0", obs_i[0], 16'hA5F0);
    chk("iload_w1", obs_i[1], 16'h1234);

    // two data words plus a discarded nibble
    base_d = n_dw;
    bus.csd_n_i = 0;
    send(64'h3C81A, 20);
    bus.csd_n_i = 1;
    tick(); tick();
    chk("dload_count", n_dw - base_d, 2);
    chk("dload_w0", obs_d[0], 8'h3C);
    chk("dload_w1", obs_d[1], 8'h81);
    chk("dload_last_addr", last_da, 1);

    // 17 data words: the last one wraps to address 0
    base_d = n_dw;
    bus.csd_n_i = 0;
    for (int k = 0; k < 17; k++) send(64'(k + 8'h40), 8);
    bus.csd_n_i = 1;
    tick(); tick();
    chk("wrap_count", n_dw - base_d, 17);
    chk("wrap_last_addr", last_da, 0);
    chk("wrap_w_at0", obs_d[0], 8'h50);
    chk("wrap_w_at15", obs_d[15], 8'h4F);

    // both selects low in idle: sticky error, no strobes
    base_i = n_iw; base_d = n_dw;
    bus.csi_n_i = 0; bus.csd_n_i = 0;
    tick(); tick(); tick();
    bus.csi_n_i = 1; bus.csd_n_i = 1;
    tick(); tick();
    chk("err_set", bus.err_o, 1);
    chk("err_no_we", (n_iw - base_i) + (n_dw - base_d), 0);

    // run / done / release
    bus.proc_en_i = 1;
    tick();
    chk("run_core_rst", bus.core_rst_o, 0);
    chk("run_core_run", bus.core_run_o, 1);
    tick();
    bus.core_done_i = 1;
    tick();
    bus.core_done_i = 0;
    chk("done_flag", bus.done_o, 1);
    chk("done_run_off", bus.core_run_o, 0);
    tick();
    chk("done_sticky", bus.done_o, 1);
    bus.proc_en_i = 0;
    tick();
    chk("rel_core_rst", bus.core_rst_o, 1);
    chk("rel_done", bus.done_o, 0);
    chk("err_still_set", bus.err_o, 1);

    // async reset in the middle of an instruction word
    base_i = n_iw;
    bus.csi_n_i = 0;
    send(64'h55, 7);
    #1 rst = 1;
    bus.csi_n_i = 1;
    #1 chk_reset_vals("midrst");
    tick();
    rst = 0;
    tick();
    chk("midrst_no_we", n_iw - base_i, 0);
    bus.csi_n_i = 0;
    send(64'hBEEF, 16);
    bus.csi_n_i = 1;
    tick(); tick();
    chk("midrst_new_count", n_iw - base_i, 1);
    chk("midrst_new_addr", last_ia, 0);
    chk("midrst_new_word", obs_i[0], 16'hBEEF);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(11) == 0) bus.csi_n_i = ~bus.csi_n_i;
      if ($urandom_range(11) == 0) bus.csd_n_i = ~bus.csd_n_i;
      if ($urandom_range(39) == 0) bus.proc_en_i = ~bus.proc_en_i;
      bus.core_done_i = ($urandom_range(7) == 0);
      bus.mosi_i      = 1'($urandom);
      if ($urandom_range(599) == 0) begin
        #1 rst = 1;
        tick();
        rst = 0;
      end else begin
        tick();
      end
    end

    bus.csi_n_i = 1; bus.csd_n_i = 1; bus.proc_en_i = 0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
